// File: rtl/stl_pkg.sv
// Shared definitions for the stage-level pipeline controllers.
package stl_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/stl_reg_sr.sv
// Write-enabled payload register with synchronous active-high reset.
module stl_reg_sr #(
   parameter int unsigned           WIDTH     = 64,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= RESET_VAL;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/stl_pipe_ctrl.sv
// Valid/ready stage controller: main + skid register, registered upstream ready,
// one transfer per cycle, flush on redirect.
module stl_pipe_ctrl
   import stl_pkg::*;
#(
   parameter int unsigned      WIDTH     = 64,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_pre_valid,
   output logic             o_pre_ready,
   input  logic [WIDTH-1:0] i_pre_data,
   output logic             o_post_valid,
   input  logic             i_post_ready,
   output logic [WIDTH-1:0] o_post_data,
   output logic [1:0]       o_occ
);

   pipe_state_e      r_state;
   pipe_state_e      w_state_d;
   logic             r_pre_ready;
   logic             w_in_fire;
   logic             w_out_fire;
   logic             w_m_we;
   logic             w_s_we;
   logic             w_m_sel_s;
   logic [WIDTH-1:0] w_m_din;
   logic [WIDTH-1:0] w_m_q;
   logic [WIDTH-1:0] w_s_q;

   assign o_post_valid = (r_state != EMPTY);
   assign w_in_fire    = i_pre_valid & r_pre_ready;
   assign w_out_fire   = o_post_valid & i_post_ready;

   always_comb begin
      w_state_d = r_state;
      w_m_we    = 1'b0;
      w_s_we    = 1'b0;
      w_m_sel_s = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in_fire) begin
               w_m_we    = 1'b1;
               w_state_d = BUSY;
            end
         end
         BUSY: begin
            if (w_in_fire && w_out_fire) begin
               w_m_we = 1'b1;
            end else if (w_out_fire) begin
               w_state_d = EMPTY;
            end else if (w_in_fire) begin
               w_s_we    = 1'b1;
               w_state_d = FULL;
            end
         end
         FULL: begin
            if (w_out_fire) begin
               w_m_we    = 1'b1;
               w_m_sel_s = 1'b1;
               w_state_d = BUSY;
            end
         end
         default: w_state_d = EMPTY;
      endcase
      // Flush drops everything, including a same-cycle accepted input.
      if (i_flush) begin
         w_state_d = EMPTY;
         w_m_we    = 1'b0;
         w_s_we    = 1'b0;
      end
   end

   assign w_m_din = w_m_sel_s ? w_s_q : i_pre_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= EMPTY;
         r_pre_ready <= 1'b1;
      end else begin
         r_state     <= w_state_d;
         r_pre_ready <= (w_state_d != FULL);
      end
   end

   stl_reg_sr #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_main (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_we  (w_m_we),
      .i_d   (w_m_din),
      .o_q   (w_m_q)
   );

   stl_reg_sr #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
   ) u_skid (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_we  (w_s_we),
      .i_d   (i_pre_data),
      .o_q   (w_s_q)
   );

   assign o_pre_ready = r_pre_ready;
   assign o_post_data = w_m_q;
   assign o_occ       = r_state;

endmodule

// File: tb/tb_stl_pipe_ctrl.sv
// Scoreboard bench for stl_pipe_ctrl: a queue model predicts occupancy, ready and payload order.
module tb_stl_pipe_ctrl;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         pre_valid;
   logic         pre_ready;
   logic [W-1:0] pre_data;
   logic         post_valid;
   logic         post_ready;
   logic [W-1:0] post_data;
   logic [1:0]   occ;

   int           n_total = 0;
   int           n_bad   = 0;
   logic [W-1:0] sb_q[$];
   bit           m_ready = 1'b1;
   logic [W-1:0] popped;

   always #5 clk = ~clk;

   stl_pipe_ctrl #(
      .WIDTH     (W),
      .RESET_VAL ('0)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_flush      (flush),
      .i_pre_valid  (pre_valid),
      .o_pre_ready  (pre_ready),
      .i_pre_data   (pre_data),
      .o_post_valid (post_valid),
      .i_post_ready (post_ready),
      .o_post_data  (post_data),
      .o_occ        (occ)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive inputs, compare the state-driven outputs, then advance the model.
   task automatic cyc(input bit v, input logic [W-1:0] d, input bit pr, input bit fl,
                      input bit rs, input bit do_chk);
      bit inf;
      bit outf;
      pre_valid  = v;
      pre_data   = d;
      post_ready = pr;
      flush      = fl;
      rst        = rs;
      #1;
      if (do_chk) begin
         check("occ", W'(occ), W'(sb_q.size()));
         check("pre_ready", W'(pre_ready), W'(m_ready));
         check("post_valid", W'(post_valid), W'(sb_q.size() != 0));
         if (sb_q.size() != 0) check("data", post_data, sb_q[0]);
      end
      inf  = v && m_ready;
      outf = (sb_q.size() != 0) && pr;
      @(posedge clk);
      if (rs || fl) begin
         sb_q.delete();
         m_ready = 1'b1;
      end else begin
         if (outf) popped = sb_q.pop_front();
         if (inf) sb_q.push_back(d);
         m_ready = (sb_q.size() != 2);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; pre_valid = 1'b0; pre_data = '0; post_ready = 1'b0;
      @(negedge clk);

      // Reset with valid asserted: nothing captured, payload at reset value.
      cyc(1, 64'hDEAD, 0, 0, 1, 0);
      cyc(1, 64'hBEEF, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1);
      check("rst_data", post_data, '0);

      // Streaming 1..8 back-to-back.
      for (int i = 1; i <= 8; i++) cyc(1, W'(i), 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);

      // Backpressure: A then B fill the stage, then drain in order.
      cyc(1, 64'hA, 0, 0, 0, 1);
      cyc(1, 64'hB, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);

      // Flush while full with a same-cycle input 0xC.
      cyc(1, 64'hA, 0, 0, 0, 1);
      cyc(1, 64'hB, 0, 0, 0, 1);
      cyc(1, 64'hC, 0, 1, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);

      // Reset mid-backpressure, then a lone 0x5.
      cyc(1, 64'hA, 0, 0, 0, 1);
      cyc(1, 64'hB, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 1);
      check("rst2_data", post_data, '0);
      cyc(1, 64'h5, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);
      cyc(0, 0, 1, 0, 0, 1);

      // Random traffic with occasional flush.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 9) < 6,
             $urandom_range(0, 9) == 0, 0, 1);
      end
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
